// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester and SRAM-driver bus seen by ram_arbiter.
// master = arbiter side, slave = environment side (CPU pipeline + driver).
interface ram_arbiter_if;
    // instruction-fetch requester
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ready_o;
    // data-access requester
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_o;
    logic        mem_ready_o;
    // pipeline status
    logic        stall_o;
    logic        timeout_o;
    // SRAM driver request port
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_data_i;
    logic        ram_ready_i;

    modport master (
        input  if_req_i, if_addr_i,
        input  mem_req_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i,
        input  ram_data_i, ram_ready_i,
        output if_data_o, if_ready_o, mem_data_o, mem_ready_o,
        output stall_o, timeout_o,
        output ram_ce_o, ram_we_o, ram_addr_o, ram_data_o, ram_sel_o
    );

    modport slave (
        output if_req_i, if_addr_i,
        output mem_req_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i,
        output ram_data_i, ram_ready_i,
        input  if_data_o, if_ready_o, mem_data_o, mem_ready_o,
        input  stall_o, timeout_o,
        input  ram_ce_o, ram_we_o, ram_addr_o, ram_data_o, ram_sel_o
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises IF and MEM requests onto the single SRAM-driver
// port, MEM first. After each completion ce is held low for RELEASE + IDLE
// so the driver's step counter clears and the still-asserted request is
// not replayed.
// Optional feature: define RAM_ARB_TIMEOUT_EN to force completion with
// data 32'hFFFFFFFF after 100 BUSY cycles without ram_ready_i and set the
// sticky timeout_o flag.
module ram_arbiter (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        grant_mem_reg, grant_mem_next;
    logic        ce_reg, ce_next;
    logic        we_reg, we_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  sel_reg, sel_next;
    logic [31:0] if_data_reg, if_data_next;
    logic [31:0] mem_data_reg, mem_data_next;
    logic        if_ready_reg, if_ready_next;
    logic        mem_ready_reg, mem_ready_next;
    logic        expired;
    logic        done;
    logic [31:0] result;

`ifdef RAM_ARB_TIMEOUT_EN
    logic [6:0] count_reg, count_next;
    logic       timeout_reg, timeout_next;

    // 100th BUSY cycle with no driver answer; a real answer always wins
    assign expired = (state_reg == BUSY) && !bus.ram_ready_i && (count_reg == 7'd99);

    // BUSY cycle counter (zero on the first BUSY cycle) and sticky flag
    always_comb begin
        count_next   = (state_reg == BUSY) ? count_reg + 7'd1 : 7'd0;
        timeout_next = timeout_reg | expired;
    end

    // timeout state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg   <= 7'd0;
            timeout_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            timeout_reg <= timeout_next;
        end
    end

    assign bus.timeout_o = timeout_reg;
`else
    assign expired       = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    assign done   = (state_reg == BUSY) && (bus.ram_ready_i || expired);
    assign result = expired ? 32'hFFFF_FFFF : (we_reg ? 32'h0 : bus.ram_data_i);

    // next-state and registered-output logic; everything holds by default
    always_comb begin
        state_next     = state_reg;
        grant_mem_next = grant_mem_reg;
        ce_next        = ce_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        sel_next       = sel_reg;
        if_data_next   = if_data_reg;
        mem_data_next  = mem_data_reg;
        if_ready_next  = 1'b0;
        mem_ready_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.mem_req_i) begin
                    grant_mem_next = 1'b1;
                    ce_next        = 1'b1;
                    we_next        = bus.mem_we_i;
                    addr_next      = bus.mem_addr_i;
                    wdata_next     = bus.mem_data_i;
                    sel_next       = bus.mem_sel_i;
                    state_next     = BUSY;
                end else if (bus.if_req_i) begin
                    grant_mem_next = 1'b0;
                    ce_next        = 1'b1;
                    we_next        = 1'b0;
                    addr_next      = bus.if_addr_i;
                    sel_next       = 4'b1111;
                    state_next     = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    ce_next    = 1'b0;
                    state_next = RELEASE;
                    if (grant_mem_reg) begin
                        mem_data_next  = result;
                        mem_ready_next = 1'b1;
                    end else begin
                        if_data_next  = result;
                        if_ready_next = 1'b1;
                    end
                end
            end
            RELEASE: begin
                // requester still holds req this cycle; granting would replay it
                state_next = IDLE;
            end
            default: begin
                ce_next    = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            grant_mem_reg <= 1'b0;
            ce_reg        <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= 32'h0;
            wdata_reg     <= 32'h0;
            sel_reg       <= 4'h0;
            if_data_reg   <= 32'h0;
            mem_data_reg  <= 32'h0;
            if_ready_reg  <= 1'b0;
            mem_ready_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_mem_reg <= grant_mem_next;
            ce_reg        <= ce_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            sel_reg       <= sel_next;
            if_data_reg   <= if_data_next;
            mem_data_reg  <= mem_data_next;
            if_ready_reg  <= if_ready_next;
            mem_ready_reg <= mem_ready_next;
        end
    end

    assign bus.ram_ce_o    = ce_reg;
    assign bus.ram_we_o    = we_reg;
    assign bus.ram_addr_o  = addr_reg;
    assign bus.ram_data_o  = wdata_reg;
    assign bus.ram_sel_o   = sel_reg;
    assign bus.if_data_o   = if_data_reg;
    assign bus.mem_data_o  = mem_data_reg;
    assign bus.if_ready_o  = if_ready_reg;
    assign bus.mem_ready_o = mem_ready_reg;
    assign bus.stall_o     = (bus.if_req_i & ~if_ready_reg) | (bus.mem_req_i & ~mem_ready_reg);
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: table vectors, hand-written corner sequences and random
// traffic against a word-level memory reference model. An SRAM driver model
// answers reads after 3 ce cycles and writes after 8.
module tb_ram_arbiter;
    logic clk;
    logic rst;
    ram_arbiter_if bus ();

    ram_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model: word memory ----------------
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] drv_mem [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = ref_read(a);
        for (int b = 0; b < 4; b++)
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[a] = w;
    endfunction

    // ---------------- SRAM driver model ----------------
    int drv_cnt = 0;
    int drv_txn = 0;
    bit drv_hang = 0;

    initial begin
        logic [31:0] old, mask;
        bus.ram_ready_i = 1'b0;
        bus.ram_data_i  = 32'h0;
        forever begin
            @(posedge clk); #1;
            bus.ram_ready_i = 1'b0;
            if (bus.ram_ce_o) begin
                if (drv_cnt == 0) drv_txn++;
                drv_cnt++;
                if (!drv_hang && drv_cnt == (bus.ram_we_o ? 8 : 3)) begin
                    bus.ram_ready_i = 1'b1;
                    if (bus.ram_we_o) begin
                        old  = drv_mem.exists(bus.ram_addr_o) ? drv_mem[bus.ram_addr_o] : dflt(bus.ram_addr_o);
                        mask = {{8{bus.ram_sel_o[3]}}, {8{bus.ram_sel_o[2]}},
                                {8{bus.ram_sel_o[1]}}, {8{bus.ram_sel_o[0]}}};
                        drv_mem[bus.ram_addr_o] = (old & ~mask) | (bus.ram_data_o & mask);
                        bus.ram_data_i = $urandom | 32'h1;
                    end else begin
                        bus.ram_data_i = drv_mem.exists(bus.ram_addr_o) ? drv_mem[bus.ram_addr_o]
                                                                        : dflt(bus.ram_addr_o);
                    end
                end
            end else begin
                drv_cnt = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // one complete access: request, wait for pulse, drop req one cycle later
    task automatic run_access(input string name, input bit is_mem, input bit we,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] sel, input logic [31:0] exp);
        int  cyc, lat, txn0;
        bit  seen, bus_ok, stall_ok, other_ok;
        logic [31:0] got;
        txn0 = drv_txn; cyc = 0; seen = 0; bus_ok = 1; stall_ok = 1; other_ok = 1;
        lat = (is_mem && we) ? 8 : 3;
        if (is_mem) begin
            bus.mem_req_i = 1'b1; bus.mem_we_i = we; bus.mem_addr_i = addr;
            bus.mem_data_i = wdata; bus.mem_sel_i = sel;
        end else begin
            bus.if_req_i = 1'b1; bus.if_addr_i = addr;
        end
        while (!seen && cyc < 200) begin
            tick(); cyc++;
            if ((is_mem ? bus.mem_ready_o : bus.if_ready_o) === 1'b1) begin
                seen = 1;
            end else begin
                if (bus.stall_o !== 1'b1) stall_ok = 0;
                if (bus.ram_ce_o === 1'b1) begin
                    if (bus.ram_addr_o !== addr) bus_ok = 0;
                    if (bus.ram_we_o !== (is_mem & we)) bus_ok = 0;
                    if (bus.ram_sel_o !== (is_mem ? sel : 4'b1111)) bus_ok = 0;
                    if (is_mem && we && bus.ram_data_o !== wdata) bus_ok = 0;
                end
            end
            if ((is_mem ? bus.if_ready_o : bus.mem_ready_o) !== 1'b0) other_ok = 0;
        end
        got = is_mem ? bus.mem_data_o : bus.if_data_o;
        check({name, "_ready_seen"}, 32'(seen), 32'd1);
        check({name, "_latency"}, cyc, lat + 1);
        check({name, "_data"}, got, exp);
        check({name, "_ce_in_pulse"}, 32'(bus.ram_ce_o), 32'd0);
        check({name, "_stall_in_pulse"}, 32'(bus.stall_o), 32'd0);
        check({name, "_bus_stall_hold"}, {29'd0, bus_ok, stall_ok, other_ok}, 32'd7);
        tick();
        if (is_mem) bus.mem_req_i = 1'b0; else bus.if_req_i = 1'b0;
        check({name, "_ready_one_cycle"}, 32'(is_mem ? bus.mem_ready_o : bus.if_ready_o), 32'd0);
        check({name, "_ce_release"}, 32'(bus.ram_ce_o), 32'd0);
        tick();
        check({name, "_ce_no_replay"}, 32'(bus.ram_ce_o), 32'd0);
        check({name, "_one_txn"}, drv_txn - txn0, 32'd1);
        check({name, "_data_held"}, is_mem ? bus.mem_data_o : bus.if_data_o, exp);
        $display("txn %s mem=%0b we=%0b addr=%h sel=%h data=%h cycles=%0d",
                 name, is_mem, we, addr, sel, got, cyc);
    endtask

    typedef struct packed {
        bit          is_mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int txn0, cyc;
        bit seen, first_if, stuck, any_ready;
        logic [31:0] a, d, e;
        logic [3:0] s;
        bit m, w;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          4'h0,    32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h0040_0008, 32'h1234_5678, 4'b0011, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0040_0008, 32'h0,          4'hF,    32'h0008_5678};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b1111, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,          4'h0,    32'hAABB_CCDD};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1000, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,          4'h0,    32'h11BB_CCDD};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,          4'h0,    32'h0044_FFBB};

        ref_mem[32'h10] = 32'hDEAD_BEEF;
        drv_mem[32'h10] = 32'hDEAD_BEEF;

        rst = 1'b1;
        bus.if_req_i = 0; bus.if_addr_i = 0;
        bus.mem_req_i = 0; bus.mem_we_i = 0; bus.mem_addr_i = 0; bus.mem_data_i = 0; bus.mem_sel_i = 0;
        repeat (3) tick();
        check("rst_ce", 32'(bus.ram_ce_o), 0);
        check("rst_we", 32'(bus.ram_we_o), 0);
        check("rst_addr", bus.ram_addr_o, 0);
        check("rst_wdata", bus.ram_data_o, 0);
        check("rst_sel", 32'(bus.ram_sel_o), 0);
        check("rst_if_data", bus.if_data_o, 0);
        check("rst_mem_data", bus.mem_data_o, 0);
        check("rst_if_ready", 32'(bus.if_ready_o), 0);
        check("rst_mem_ready", 32'(bus.mem_ready_o), 0);
        check("rst_timeout", 32'(bus.timeout_o), 0);
        check("rst_stall", 32'(bus.stall_o), 0);
        rst = 1'b0;
        tick();

        // ---- table vectors ----
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_mem && vecs[i].we) ref_write(vecs[i].addr, vecs[i].wdata, vecs[i].sel);
            run_access($sformatf("vec%0d", i), vecs[i].is_mem, vecs[i].we, vecs[i].addr,
                       vecs[i].wdata, vecs[i].sel, vecs[i].exp);
        end

        // ---- simultaneous IF + MEM: MEM first, 2 ce-low cycles, then IF ----
        txn0 = drv_txn;
        bus.if_req_i = 1; bus.if_addr_i = 32'h10;
        bus.mem_req_i = 1; bus.mem_we_i = 1; bus.mem_addr_i = 32'h200;
        bus.mem_data_i = 32'hCAFE_F00D; bus.mem_sel_i = 4'hF;
        ref_write(32'h200, 32'hCAFE_F00D, 4'hF);
        cyc = 0; seen = 0; first_if = 0;
        while (!seen && cyc < 200) begin
            tick(); cyc++;
            if (bus.if_ready_o) first_if = 1;
            if (bus.mem_ready_o) seen = 1;
        end
        check("sim_mem_done", 32'(seen), 1);
        check("sim_if_not_first", 32'(first_if), 0);
        check("sim_mem_data", bus.mem_data_o, 0);
        check("sim_ce_release", 32'(bus.ram_ce_o), 0);
        tick();
        bus.mem_req_i = 0;
        check("sim_ce_idle", 32'(bus.ram_ce_o), 0);
        check("sim_stall_if_wait", 32'(bus.stall_o), 1);
        tick();
        check("sim_if_grant_ce", 32'(bus.ram_ce_o), 1);
        check("sim_if_grant_addr", bus.ram_addr_o, 32'h10);
        check("sim_if_grant_we", 32'(bus.ram_we_o), 0);
        cyc = 0; seen = 0;
        while (!seen && cyc < 200) begin
            tick(); cyc++;
            if (bus.if_ready_o) seen = 1;
        end
        check("sim_if_done", 32'(seen), 1);
        check("sim_if_data", bus.if_data_o, 32'hDEAD_BEEF);
        tick();
        bus.if_req_i = 0;
        check("sim_if_ready_one", 32'(bus.if_ready_o), 0);
        tick();
        check("sim_two_txn", drv_txn - txn0, 2);
        check("sim_readback", ref_read(32'h200), drv_mem[32'h200]);
        $display("txn sim_if_mem mem_first=%0b", !first_if);

        // ---- reset in 2nd BUSY cycle, request held, access replays ----
        txn0 = drv_txn;
        bus.if_req_i = 1; bus.if_addr_i = 32'h44;
        tick();
        check("rstb_busy1_ce", 32'(bus.ram_ce_o), 1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        check("rstb_ce", 32'(bus.ram_ce_o), 0);
        check("rstb_if_ready", 32'(bus.if_ready_o), 0);
        check("rstb_addr", bus.ram_addr_o, 0);
        check("rstb_if_data", bus.if_data_o, 0);
        check("rstb_mem_data", bus.mem_data_o, 0);
        run_access("rstb_replay", 0, 0, 32'h44, 0, 0, ref_read(32'h44));
        check("rstb_two_txn", drv_txn - txn0, 2);

        // ---- randomized traffic against the reference model ----
        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom_range(0, 1));
            w = m ? 1'($urandom_range(0, 1)) : 1'b0;
            a = 32'h100 + (32'($urandom_range(0, 15)) << 2);
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            if (m && w) begin
                e = 32'h0;
                ref_write(a, d, s);
            end else begin
                e = ref_read(a);
            end
            run_access($sformatf("rnd%0d", i), m, w, a, d, s, e);
            repeat ($urandom_range(0, 2)) tick();
        end

        // ---- driver never answers ----
        drv_hang = 1;
`ifdef RAM_ARB_TIMEOUT_EN
        bus.mem_req_i = 1; bus.mem_we_i = 0; bus.mem_addr_i = 32'h104; bus.mem_sel_i = 4'hF;
        cyc = 0; seen = 0;
        while (!seen && cyc < 300) begin
            tick(); cyc++;
            if (bus.mem_ready_o) seen = 1;
        end
        check("to_ready_seen", 32'(seen), 1);
        check("to_cycles", cyc, 101);
        check("to_data", bus.mem_data_o, 32'hFFFF_FFFF);
        check("to_flag", 32'(bus.timeout_o), 1);
        tick();
        bus.mem_req_i = 0;
        drv_hang = 0;
        tick();
        run_access("to_after", 1, 0, 32'h104, 0, 4'hF, ref_read(32'h104));
        check("to_flag_sticky", 32'(bus.timeout_o), 1);
        rst = 1;
        tick();
        rst = 0;
        check("to_flag_cleared", 32'(bus.timeout_o), 0);
        $display("txn timeout cycles=%0d", cyc);
`else
        bus.mem_req_i = 1; bus.mem_we_i = 0; bus.mem_addr_i = 32'h104; bus.mem_sel_i = 4'hF;
        stuck = 1; any_ready = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (bus.stall_o !== 1'b1) stuck = 0;
            if (bus.mem_ready_o !== 1'b0) any_ready = 1;
        end
        check("hang_stall_stuck", 32'(stuck), 1);
        check("hang_no_ready", 32'(any_ready), 0);
        check("hang_timeout_zero", 32'(bus.timeout_o), 0);
        check("hang_ce_held", 32'(bus.ram_ce_o), 1);
        drv_hang = 0;
        rst = 1;
        tick();
        rst = 0;
        check("hang_rst_ce", 32'(bus.ram_ce_o), 0);
        run_access("hang_replay", 1, 0, 32'h104, 0, 4'hF, ref_read(32'h104));
        $display("txn hang stall_stuck=%0b", stuck);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Bus initiator between the CPU pipeline and the `ram` SRAM driver. It accepts instruction-fetch and data-access requests, serialises them onto the driver's single request port (`ce_i`/`we_i`/`addr_i`/`data_i`/`sel_i`), waits for `ready_o`, and returns the result to the requester. It generates the pipeline stall and enforces the driver's rule that `ce_i` must drop between transactions, so the driver's step counter clears.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `if_req_i` in 1: fetch request, level, held until `if_ready_o`.
- `if_addr_i` in 32: fetch byte address.
- `if_data_o` out 32: fetched word.
- `if_ready_o` out 1: one-cycle completion pulse for the fetch.
- `mem_req_i` in 1: data request, level, held until `mem_ready_o`.
- `mem_we_i` in 1: 1 = write, 0 = read.
- `mem_addr_i` in 32: data byte address.
- `mem_data_i` in 32: store data.
- `mem_sel_i` in 4: byte lane enables (bit 3 = [31:24]).
- `mem_data_o` out 32: load word; zero for writes.
- `mem_ready_o` out 1: one-cycle completion pulse for the data access.
- `stall_o` out 1: pipeline stall.
- `timeout_o` out 1: sticky timeout flag (see Configuration).
- `ram_ce_o` out 1: to driver `ce_i`; 1 = enable.
- `ram_we_o` out 1: to driver `we_i`; 1 = write.
- `ram_addr_o` out 32, `ram_data_o` out 32, `ram_sel_o` out 4: to driver `addr_i`, `data_i`, `sel_i`.
- `ram_data_i` in 32, `ram_ready_i` in 1: from driver `data_o`, `ready_o`.

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - If `mem_req_i`=1, grant MEM and latch `mem_we_i`/`mem_addr_i`/`mem_data_i`/`mem_sel_i` into the `ram_*` output registers.
  - Else if `if_req_i`=1, grant IF and latch `if_addr_i`, with we=0 and sel=4'b1111.
  - On a grant, set `ram_ce_o`=1 and go to BUSY. Otherwise stay in IDLE.
  - MEM always has priority over IF.
- BUSY:
  - The `ram_*` outputs stay frozen. Changes on requester inputs are ignored.
  - When `ram_ready_i`=1: capture `ram_data_i` into the granted requester's `*_data_o` (forced to zero if the granted access is a write). Pulse that requester's `*_ready_o` for one cycle. Set `ram_ce_o`=0 and go to RELEASE.
- RELEASE:
  - `ram_ce_o` stays 0. Always go to IDLE; no grant is made.
  - Reason: the requester still shows `req`=1 in this cycle, and a grant here would replay its access.
- `*_data_o` holds its value until the next completion for the same requester.
- `stall_o` is combinational and equals (`if_req_i` & ~`if_ready_o`) | (`mem_req_i` & ~`mem_ready_o`).
- Reset: synchronous `rst` forces IDLE on the next edge, including in the middle of BUSY. The abandoned driver access is dropped because `ce` falls.
  - Reset values: `ram_ce_o`=0, `ram_we_o`=0, `ram_addr_o`/`ram_data_o`=0, `ram_sel_o`=0, `if_data_o`/`mem_data_o`=0, both ready pulses 0, `timeout_o`=0.

## Timing
- Grant edge → `ram_ce_o`=1 in the next cycle.
- `*_ready_o` is high in the cycle after the edge where `ram_ready_i`=1 is sampled, and `ram_ce_o` is 0 in that same cycle.
- `ram_ce_o` is low for at least 2 cycles (RELEASE + IDLE) between transactions.
- Minimum occupancy per transaction is 3 cycles plus the driver's latency:
  - about 3 cycles for a read,
  - 8 for a full-word write,
  - 8 for a partial write.
- Simultaneous IF and MEM requests: MEM completes first. IF is granted on the IDLE that follows MEM's RELEASE.
- `ram_ready_i` is ignored outside BUSY.

## Configuration
- `RAM_ARB_TIMEOUT_EN` defined:
  - A 7-bit counter runs in BUSY and clears when BUSY is entered.
  - If the counter reaches 100 cycles without `ram_ready_i`, the transaction completes anyway: `*_data_o`=32'hFFFFFFFF, the `*_ready_o` pulse is issued, RELEASE is entered, and `timeout_o` is set to 1.
  - `timeout_o` stays set until `rst`.
- `RAM_ARB_TIMEOUT_EN` undefined:
  - No counter. BUSY waits indefinitely.
  - `timeout_o` is tied to 0.

## Test plan
- IF read at 0x00000010, driver model returns 0xDEADBEEF after 3 cycles → `if_data_o`=0xDEADBEEF; `if_ready_o` high exactly 1 cycle; `ram_sel_o`=4'b1111; `ram_we_o`=0; `stall_o` high until the pulse.
- MEM write 0x12345678, sel=4'b0011, addr 0x00400008 → `ram_we_o`=1 and `ram_addr_o`=0x00400008 held through BUSY; `mem_data_o`=0; `mem_ready_o` pulses once.
- IF and MEM requests raised in the same cycle → MEM granted first. After MEM's ready, `ram_ce_o` stays 0 for 2 cycles, then IF is granted. Each ready pulses once.
- Back-to-back: requester drops `req` the cycle after its ready pulse → no second driver transaction is issued; `ram_ce_o` stays 0.
- `rst` asserted in the 2nd BUSY cycle → next cycle `ram_ce_o`=0, state IDLE, no ready pulse. After `rst` is released and `req` is still held, the access replays from the start.
- With `RAM_ARB_TIMEOUT_EN`, driver never asserts ready → after 100 BUSY cycles `mem_data_o`=0xFFFFFFFF, `mem_ready_o` pulses, `timeout_o`=1 and stays set. Without the macro, the bench sees `stall_o` stuck at 1 and `timeout_o`=0.
